// File: rtl/matrix_ram_ctrl.sv
// Sequencer for the 8x8 matrix store: loads one matrix row-major from a stream,
// then walks the column-read address 0..7 toward the consumer for PASSES passes.
module matrix_ram_ctrl #(
  parameter int SIZE   = 16,
  parameter int PASSES = 1
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            in_valid,
  input  logic [SIZE-1:0] in_data,
  output logic            in_ready,
  output logic            ram_wen,
  output logic [2:0]      ram_wi,
  output logic [2:0]      ram_wj,
  output logic [SIZE-1:0] ram_wdata,
  output logic [2:0]      ram_rj,
  output logic            col_valid,
  input  logic            col_ready,
  output logic            col_last,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, LOAD, READ, FIN} state_t;

  localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

  state_t     state, state_nxt;
  logic [2:0] row, col, rd;
  logic [7:0] pass;
  logic       accept, handshake, load_end;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: if (accept && load_end) state_nxt = READ;
      READ: if (handshake && col_last) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    accept    = in_valid & in_ready;
    load_end  = (row == 3'd7) && (col == 3'd7);
    ram_wen   = accept;
    ram_wi    = (state == LOAD) ? row : 3'd0;
    ram_wj    = (state == LOAD) ? col : 3'd0;
    ram_wdata = (state == LOAD) ? in_data : '0;
    col_valid = (state == READ);
    ram_rj    = (state == READ) ? rd : 3'd0;
    col_last  = col_valid && (rd == 3'd7) && (pass == LAST_PASS);
    handshake = col_valid & col_ready;
    busy      = (state != IDLE);
    done      = (state == FIN);
  end

  // Row/col advance row-major; the read counter wraps naturally and bumps the pass count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row  <= 3'd0;
      col  <= 3'd0;
      rd   <= 3'd0;
      pass <= 8'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row  <= 3'd0;
          col  <= 3'd0;
          rd   <= 3'd0;
          pass <= 8'd0;
        end
        LOAD: if (accept) begin
          col <= col + 3'd1;
          if (col == 3'd7) row <= row + 3'd1;
          if (load_end) begin
            rd   <= 3'd0;
            pass <= 8'd0;
          end
        end
        READ: if (handshake) begin
          rd <= rd + 3'd1;
          if (rd == 3'd7) pass <= pass + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
